// File: rtl/offchip_mem_model_nch.sv
// Behavioural multi-channel off-chip memory model with per-channel latency FSMs.
// Define OFFCHIP_MEM_HALT_ON_ERROR_EN to end the simulation on any protocol error.
module offchip_mem_model_nch #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned BITSIZE_DATA = 16,
    parameter int unsigned BITSIZE_ADDR = 10,
    parameter int unsigned BITSIZE_SIZE = 5,
    parameter int unsigned MEM_BYTES    = 64,
    parameter int unsigned READ_DELAY   = 2,
    parameter int unsigned WRITE_DELAY  = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [31:0]                    base_addr,
    input  logic                           init_we,
    input  logic [31:0]                    init_addr,
    input  logic [7:0]                     init_data,
    input  logic [N_CH-1:0]                oe_ram,
    input  logic [N_CH-1:0]                we_ram,
    input  logic [N_CH*BITSIZE_ADDR-1:0]   addr_ram,
    input  logic [N_CH*BITSIZE_DATA-1:0]   Wdata_ram,
    input  logic [N_CH*BITSIZE_SIZE-1:0]   data_ram_size,
    output logic [N_CH*BITSIZE_DATA-1:0]   Rdata_ram,
    output logic [N_CH-1:0]                DataRdy,
    output logic                           err_oe_we,
    output logic [N_CH-1:0]                err_ch
);

    localparam int unsigned DW     = BITSIZE_DATA;
    localparam int unsigned NBYTES = BITSIZE_DATA / 8;
    localparam int unsigned IW     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned CW     = 16;

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

    logic [7:0]    mem_q [MEM_BYTES];

    state_e        state_q [N_CH];
    state_e        state_d [N_CH];
    logic [CW-1:0] cnt_q   [N_CH];
    logic [CW-1:0] cnt_d   [N_CH];
    logic [DW-1:0] snap_q  [N_CH];
    logic [DW-1:0] snap_d  [N_CH];
    logic [DW-1:0] rdata_q [N_CH];
    logic [DW-1:0] rdata_d [N_CH];
    logic [N_CH-1:0] rdy_q, rdy_d;
    logic            err_oe_we_q, err_oe_we_d;
    logic [N_CH-1:0] err_ch_q, err_ch_d;

    // Per-channel request decode
    int unsigned   nb      [N_CH];
    logic [DW-1:0] mask    [N_CH];
    logic [DW-1:0] rd_val  [N_CH];
    logic [N_CH-1:0] in_win, rd_go, wr_go, coll, oow;

    logic          wr_en   [N_CH][NBYTES];
    logic [IW-1:0] wr_idx  [N_CH][NBYTES];
    logic [7:0]    wr_byte [N_CH][NBYTES];

    logic          init_ok;
    logic [IW-1:0] init_idx;

    always_comb begin
        int unsigned sz_eff;
        logic [33:0] addr_x;
        logic [33:0] base_x;
        logic [33:0] off_x;
        logic [33:0] idx_x;
        logic        idle;
        logic        oe;
        logic        we;
        sz_eff = 0;
        addr_x = '0;
        base_x = {2'b00, base_addr};
        off_x  = '0;
        idx_x  = '0;
        idle   = 1'b0;
        oe     = 1'b0;
        we     = 1'b0;
        in_win = '0;
        rd_go  = '0;
        wr_go  = '0;
        coll   = '0;
        oow    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            oe     = oe_ram[i];
            we     = we_ram[i];
            addr_x = 34'(addr_ram[i*BITSIZE_ADDR +: BITSIZE_ADDR]);
            sz_eff = 32'(data_ram_size[i*BITSIZE_SIZE +: BITSIZE_SIZE]);
            if (sz_eff == 0 || sz_eff > DW) begin
                sz_eff = DW;
            end
            nb[i]     = (sz_eff + 7) / 8;
            mask[i]   = {DW{1'b1}} >> (DW - sz_eff);
            in_win[i] = (addr_x >= base_x) &&
                        ((addr_x + 34'(nb[i])) <= (base_x + 34'(MEM_BYTES)));
            off_x     = addr_x - base_x;
            rd_val[i] = '0;
            for (int unsigned k = 0; k < NBYTES; k++) begin
                idx_x         = off_x + 34'(k);
                wr_idx[i][k]  = idx_x[IW-1:0];
                wr_en[i][k]   = 1'b0;
                wr_byte[i][k] = Wdata_ram[i*DW + 8*k +: 8];
                if (in_win[i] && k < nb[i] && idx_x < 34'(MEM_BYTES)) begin
                    rd_val[i][8*k +: 8] = mem_q[idx_x[IW-1:0]];
                    wr_byte[i][k] = (Wdata_ram[i*DW + 8*k +: 8] & mask[i][8*k +: 8]) |
                                    (mem_q[idx_x[IW-1:0]] & ~mask[i][8*k +: 8]);
                    wr_en[i][k]   = 1'b1;
                end
            end
            rd_val[i] = rd_val[i] & mask[i];
            idle      = (state_q[i] == StIdle) && !reset;
            coll[i]   = idle && oe && we;
            oow[i]    = idle && (oe ^ we) && !in_win[i];
            rd_go[i]  = idle && oe && !we && in_win[i];
            wr_go[i]  = idle && we && !oe && in_win[i];
            for (int unsigned k = 0; k < NBYTES; k++) begin
                wr_en[i][k] = wr_en[i][k] && wr_go[i];
            end
        end
        init_ok  = init_we && (init_addr < 32'(MEM_BYTES));
        init_idx = init_addr[IW-1:0];
    end

    // Higher channel indices are applied later, so they win on a shared byte;
    // every channel write also overrides a colliding preload.
    always_ff @(posedge clock) begin
        if (init_ok) begin
            mem_q[init_idx] <= init_data;
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (wr_en[i][k]) begin
                    mem_q[wr_idx[i][k]] <= wr_byte[i][k];
                end
            end
        end
    end

    // Channel FSMs; DataRdy is raised on the last WAIT cycle so a request still held
    // during the pulse is ignored.
    always_comb begin
        rdy_d       = '0;
        err_oe_we_d = err_oe_we_q | (|coll);
        err_ch_d    = err_ch_q | coll | oow;
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            snap_d[i]  = snap_q[i];
            rdata_d[i] = rdata_q[i];
            case (state_q[i])
                StIdle: begin
                    if (rd_go[i]) begin
                        state_d[i] = StRdWait;
                        cnt_d[i]   = CW'(1);
                        snap_d[i]  = rd_val[i];
                        if (READ_DELAY == 1) begin
                            rdy_d[i]   = 1'b1;
                            rdata_d[i] = rd_val[i];
                        end
                    end else if (wr_go[i]) begin
                        state_d[i] = StWrWait;
                        cnt_d[i]   = CW'(1);
                        if (WRITE_DELAY == 1) begin
                            rdy_d[i] = 1'b1;
                        end
                    end else if (oow[i]) begin
                        rdata_d[i] = '0;
                    end
                end
                StRdWait: begin
                    if (rdy_q[i]) begin
                        state_d[i] = StIdle;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        if (cnt_d[i] == CW'(READ_DELAY)) begin
                            rdy_d[i]   = 1'b1;
                            rdata_d[i] = snap_q[i];
                        end
                    end
                end
                StWrWait: begin
                    if (rdy_q[i]) begin
                        state_d[i] = StIdle;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        if (cnt_d[i] == CW'(WRITE_DELAY)) begin
                            rdy_d[i] = 1'b1;
                        end
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
                snap_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
            rdy_q       <= '0;
            err_oe_we_q <= 1'b0;
            err_ch_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                snap_q[i]  <= snap_d[i];
                rdata_q[i] <= rdata_d[i];
            end
            rdy_q       <= rdy_d;
            err_oe_we_q <= err_oe_we_d;
            err_ch_q    <= err_ch_d;
        end
    end

    always_comb begin
        Rdata_ram = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            Rdata_ram[i*DW +: DW] = rdata_q[i];
        end
    end

    assign DataRdy   = rdy_q;
    assign err_oe_we = err_oe_we_q;
    assign err_ch    = err_ch_q;

`ifdef OFFCHIP_MEM_HALT_ON_ERROR_EN
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (coll[i] || oow[i]) begin
                $display("offchip_mem_model_nch: protocol error on channel %0d addr 0x%0h",
                         i, addr_ram[i*BITSIZE_ADDR +: BITSIZE_ADDR]);
                $finish;
            end
        end
    end
`else
`endif

endmodule

// File: doc/offchip_mem_model_nch.md
Name: offchip_mem_model_nch

Overview:
- Parametrised behavioural off-chip memory model for HLS co-simulation benches.
- Serves N_CH independent master channels against one byte-addressed window [base_addr, base_addr+MEM_BYTES).
- Provides configurable read and write latency, bit-size write masking, multi-byte little-endian accesses, a preload port, and detection of protocol errors.
- Sits between the DUT's Mout_* ports and the bench's file-loading logic.

Parameters:
- N_CH, 2, number of master channels.
- BITSIZE_DATA, 16, data width per channel in bits; must be a multiple of 8.
- BITSIZE_ADDR, 10, address width per channel.
- BITSIZE_SIZE, 5, width of the per-channel access-size field in bits.
- MEM_BYTES, 64, window size in bytes.
- READ_DELAY, 2, edges from request sample to read DataRdy; must be at least 1.
- WRITE_DELAY, 1, edges from request sample to write DataRdy; must be at least 1.

Ports:
- clock  in  1  single clock; all logic acts on the rising edge.
- reset  in  1  synchronous, active-high reset.
- base_addr  in  32  window base; must be stable while any request is pending.
- init_we  in  1  preload strobe; writes one byte per edge.
- init_addr  in  32  preload byte offset into the window.
- init_data  in  8  preload byte.
- oe_ram  in  N_CH  read request per channel.
- we_ram  in  N_CH  write request per channel.
- addr_ram  in  N_CH*BITSIZE_ADDR  byte address per channel.
- Wdata_ram  in  N_CH*BITSIZE_DATA  write data per channel.
- data_ram_size  in  N_CH*BITSIZE_SIZE  access size in bits, range 1..BITSIZE_DATA.
- Rdata_ram  out  N_CH*BITSIZE_DATA  read data per channel.
- DataRdy  out  N_CH  one-cycle completion pulse per channel.
- err_oe_we  out  1  sticky flag: oe and we seen high together on one channel.
- err_ch  out  N_CH  sticky per-channel error bits, covering oe/we collision and out-of-window access.

Behaviour:
- Reset:
  - Clears all channel state machines, DataRdy, Rdata_ram, err_oe_we and err_ch.
  - Memory contents are kept, so preloaded data survives.
  - A reset during a pending transaction drops it: no DataRdy pulse, and any write already committed stays.
- Per-channel FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE -> RD_WAIT when oe=1 and the access is in-window; the address is latched at that edge.
  - IDLE -> WR_WAIT when we=1 and the access is in-window.
  - A write commits its bytes at the same edge it is sampled.
  - The latency counter starts at 1 on that edge.
  - RD_WAIT: DataRdy=1 and Rdata_ram valid for exactly one cycle after the READ_DELAY-th edge (READ_DELAY=1 gives data in the cycle after sampling); then back to IDLE.
  - WR_WAIT: DataRdy=1 for one cycle after the WRITE_DELAY-th edge; then back to IDLE.
  - Request lines are ignored while in a WAIT state.
  - A request still high in IDLE after DataRdy is a new transaction.
- Bytes touched per access: nb = ceil(size/8), starting at addr, little-endian.
  - Write byte k = (Wdata[8k+7:8k] & mask_k) | (old & ~mask_k).
  - mask = (1<<size)-1, split per byte.
  - Read returns the full nb bytes; bits at and above size are zero.
- Size handling: size=0 or size>BITSIZE_DATA is treated as BITSIZE_DATA.
- Window check: addr >= base_addr and addr+nb <= base_addr+MEM_BYTES.
  - If the check fails: no FSM transition, no DataRdy, Rdata_ram=0, err_ch[i] set.
  - Other bus slaves may own that range, so the model stays silent.
- oe=1 and we=1 together on one channel in IDLE: no transaction, err_oe_we and err_ch[i] set.
  - Optionally the simulation stops (see feature).
- Simultaneous events:
  - Two channels writing the same byte on the same edge: the highest channel index wins.
  - A read sampled on the same edge as another channel's write returns the pre-write value. The read snapshot is taken at the sample edge.
  - init_we colliding with a channel write to the same byte: the channel write wins.
- Rdata_ram is held at its last value outside DataRdy cycles. It is zero after reset.

Optional Feature:
- Macro OFFCHIP_MEM_HALT_ON_ERROR_EN.
- When defined: any error-flag set event prints a $display naming the channel and address, then calls $finish on that edge.
- When undefined: flags are only recorded and the simulation continues.
- The flags behave identically in both builds.

Test Plan:
- Preload 0x34 at offset 0 and 0x12 at offset 1; base=0x40; ch0 oe, addr=0x40, size=16 sampled at edge E -> DataRdy[0]=1 and Rdata ch0=0x1234 in the cycle after edge E+1 (READ_DELAY=2); no other pulse.
- Write Wdata=0xABCD, size=4, addr=0x41 over a preloaded 0xFF byte -> DataRdy after 1 edge; a subsequent 8-bit read of 0x41 returns 0xFD.
- ch0 and ch1 both write 8-bit to 0x42 on the same edge, data 0x11 and 0x22 -> a read of 0x42 returns 0x22; a concurrent ch0 read of 0x43 during a ch1 write to 0x43 returns the old value.
- ch1 oe at addr=0x3F (below window) and at 0x7F with size 16 (straddling the top) -> no DataRdy, Rdata=0, err_ch[1]=1, err_oe_we=0.
- ch0 oe=we=1 -> err_oe_we=1 and err_ch[0]=1; with the macro defined, the simulation ends on that edge.
- Reset asserted one edge into a READ_DELAY=4 read -> DataRdy never pulses; after release, the same read completes 4 edges after re-sampling with the correct data.
